// File: rtl/fsa_stream_pkg.sv
// fsa_stream_pkg: shared constants for the fsa stream datapath.
// Buffer entry layout is {tag, data}, tag bits located by TAG_*.
package fsa_stream_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int TAG_W     = 2;
  localparam int TAG_LAST  = 0;
  localparam int TAG_USER  = 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } issue_state_e;

endpackage

// File: rtl/axis_skid_buf2.sv
// axis_skid_buf2: 2-entry tagged output buffer, head drives the stream.
// Ports: push/din write, pop advances head, occ is current fill.
import fsa_stream_pkg::*;

module axis_skid_buf2 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop & (occ != 2'd0);
  assign push_ok = push & ((occ != 2'(BUF_DEPTH)) | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++)
        mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok)
        rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push_ok}
                 - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains a sync FIFO read port into an AXI4-Stream
// master, tagging tuser/tlast per frame of cfg_len beats (0 -> 1).
import fsa_stream_pkg::*;

module fifo_axis_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy
);

  localparam int EW = DATA_WIDTH + TAG_W;

  issue_state_e         state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_in;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 inflight_q;
  logic                 acc;
  logic                 pop;
  logic                 credit;
  logic                 first;
  logic                 last;
  logic [2:0]           lvl;
  logic [1:0]           occ;
  logic [EW-1:0]        head;

  assign len_in = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
  assign pop    = m_axis_tvalid & m_axis_tready;

  // Count the in-flight read too: its data lands next cycle.
  assign lvl    = {1'b0, occ} + {2'b0, inflight_q}
                - {2'b0, pop};
  assign credit = lvl < 3'(BUF_DEPTH);
  assign acc    = fifo_rd_en & ~fifo_empty;
  assign first  = cnt_q == '0;
  assign last   = cnt_q == len_q - LEN_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    fifo_rd_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          len_d   = len_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        fifo_rd_en = credit & ~fifo_empty & ~rst;
        if (fifo_rd_en) begin
          tag_d[TAG_USER] = first;
          tag_d[TAG_LAST] = last;
          if (last) begin
            cnt_d = '0;
            if (en)
              len_d = len_in;
            else
              state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= LEN_WIDTH'(1);
      cnt_q      <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      inflight_q <= acc;
    end
  end

  axis_skid_buf2 #(
    .W (EW)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .din  ({tag_q, fifo_rd_data}),
    .pop  (pop),
    .head (head),
    .occ  (occ)
  );

  assign m_axis_tvalid = occ != 2'd0;
  assign m_axis_tdata  = head[DATA_WIDTH-1:0];
  assign m_axis_tuser  = head[DATA_WIDTH+TAG_USER];
  assign m_axis_tlast  = head[DATA_WIDTH+TAG_LAST];
  assign busy = (state_q == S_RUN) | inflight_q
              | (occ != 2'd0);

endmodule
